byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Upstream stage of the serial pattern recogniser.
- Accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO.
- Shifts bytes out MSB-first as a single-bit stream paced by a bit-enable strobe; DataOut drives the recogniser's DataIn directly.
- Back-to-back bytes produce a gapless stream; when no data is queued, the line is held at an idle level.

Parameters:
DEPTH, 4, FIFO depth in bytes (power of two, ≥2)
IDLE_LEVEL, 1'b0, value driven on DataOut when no bit is valid (0 avoids spurious runs of ones)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
DataByte  input  8  byte to serialise
ByteValid  input  1  DataByte valid
ByteReady  output  1  FIFO can accept; push = ByteValid && ByteReady at posedge
BitEn  input  1  bit-rate strobe; shifter advances only on edges where BitEn=1
DataOut  output  1  serial bit, registered
BitValid  output  1  DataOut carries a data (or parity) bit, registered
Busy  output  1  shifter active or FIFO non-empty
Level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- One clock (Clock); reset is asynchronous and active-low (Reset). Asserting Reset at any time forces the following:
  - FIFO empty (Level=0, ByteReady=1);
  - state IDLE, bit counter 0;
  - DataOut=IDLE_LEVEL, BitValid=0, Busy=0.
  - Any partially sent byte is discarded; the stream resumes only with new pushes.
- ByteReady = (Level != DEPTH), combinational from registered count. A push while full cannot occur; ByteValid with ByteReady=0 has no effect.
- Pop happens only inside the shifter load (below). The full flag is registered, so a pop on the same edge as a push when full does not admit the push.
- Push into an empty FIFO is not visible to the shifter until the next edge; there is no fall-through.
- Simultaneous push and pop when 0<Level<DEPTH: Level unchanged.
- FIFO pointers wrap modulo DEPTH.
- Shifter FSM states: IDLE, SHIFT (plus PARITY when the optional feature is enabled). Register updates occur only on edges with BitEn=1; otherwise all shifter registers hold.
  - IDLE & BitEn & Level>0:
    - pop;
    - DataOut<=byte[7]; shreg<=byte[6:0];
    - cnt<=1; BitValid<=1;
    - go to SHIFT.
  - SHIFT & BitEn & cnt<8: DataOut<=shreg[6]; shreg<<=1; cnt++.
  - SHIFT & BitEn & cnt==8:
    - if Level>0: load the next byte exactly as in IDLE, with no gap cycle;
    - else: DataOut<=IDLE_LEVEL, BitValid<=0, go to IDLE.
- Each bit is held from one enabled edge to the next, so its duration equals the BitEn period.
- Latency: byte pushed at edge N into an empty, idle block with BitEn=1 → MSB on DataOut after edge N+1; LSB after edge N+8.
- Busy = (state!=IDLE) || (Level!=0).

Optional Feature:
- Macro: BYTE_SER_PARITY_EN.
- Defined:
  - after the 8th bit, the next enabled edge enters PARITY;
  - DataOut <= even-parity bit (XOR of the 8 data bits), BitValid=1;
  - the following enabled edge applies the cnt==8 rule (load next byte or go idle);
  - 9 bits per byte.
- Undefined: PARITY state and parity logic are absent; 8 bits per byte.

Decomposition:
- Package byte_ser_pkg:
  - state enum typedef (IDLE, SHIFT, PARITY);
  - BYTE_W=8;
  - bit-counter width constant.
- Sub-module byte_ser_fifo (DEPTH-parameterised synchronous FIFO):
  - push/pop/full/empty/level;
  - same Clock/Reset.
- byte_serializer instantiates it plus the shifter FSM.

Test Plan:
- Reset released, push 8'hFD, BitEn=1 constant:
  - DataOut = 1,1,1,1,1,1,0,1 on edges 2–9, BitValid=1 for exactly those 8 cycles, then DataOut=0, BitValid=0;
  - a chained recogniser asserts MatchAll after the final 1.
- Push 8'hFD and 8'h00 back-to-back, BitEn=1: 16 contiguous BitValid cycles, with no idle cycle between the bytes.
- BitEn=0, push 5 bytes continuously: 4 accepted, then ByteReady=0 and Level=4; the 5th byte is held. Raise BitEn: ByteReady returns to 1 on the edge after the first pop.
- BitEn pulsed every 3rd cycle, byte 8'hA5: each bit held 3 cycles; sequence 1,0,1,0,0,1,0,1.
- Assert Reset after 3 bits of 8'hFF with 2 bytes queued: DataOut=0, BitValid=0, Level=0, ByteReady=1 immediately (asynchronous); no further bits after release.
- With BYTE_SER_PARITY_EN, push 8'hFD: 9 valid bits 1,1,1,1,1,1,0,1,1 (7 ones → parity 1); push 8'h03 → 9th bit 0.

Source files
------------

// File: rtl/byte_ser_pkg.sv
// Shared types and constants for the byte serializer.
// State enum includes StParity, used only when BYTE_SER_PARITY_EN is defined.
package byte_ser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = $clog2(BYTE_W) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } ser_state_e;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_ser_fifo.sv
// Synchronous byte FIFO with registered occupancy.
// push is ignored when full, pop is ignored when empty.
module byte_ser_fifo
  import byte_ser_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [BYTE_W-1:0]       wdata,
  output logic [BYTE_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Byte FIFO plus MSB-first bit shifter paced by BitEn.
// Define BYTE_SER_PARITY_EN to append an even-parity bit after each byte.
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [BYTE_W-1:0]      DataByte,
  input  logic                   ByteValid,
  output logic                   ByteReady,
  input  logic                   BitEn,
  output logic                   DataOut,
  output logic                   BitValid,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Level
);

  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty, pop;

  byte_ser_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (ByteValid),
    .pop   (pop),
    .wdata (DataByte),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Level)
  );

  ser_state_e        state_q, state_d;
  logic [BYTE_W-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              load, finish;
`ifdef BYTE_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
`ifdef BYTE_SER_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;

    if (BitEn) begin
      case (state_q)
        StIdle: load = !fifo_empty;
        StShift: begin
          if (cnt_q < CNT_W'(BYTE_W)) begin
            dout_d  = shreg_q[BYTE_W-2];
            shreg_d = {shreg_q[BYTE_W-3:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
`ifdef BYTE_SER_PARITY_EN
            state_d = StParity;
            dout_d  = par_q;
`else
            finish  = 1'b1;
`endif
          end
        end
        StParity: finish = 1'b1;
        default:  state_d = StIdle;
      endcase
    end

    // End of byte: chain straight into the next byte when one is queued.
    if (finish) begin
      if (!fifo_empty) begin
        load = 1'b1;
      end else begin
        dout_d  = IDLE_LEVEL;
        valid_d = 1'b0;
        state_d = StIdle;
      end
    end

    if (load) begin
      pop     = 1'b1;
      dout_d  = fifo_rdata[BYTE_W-1];
      shreg_d = fifo_rdata[BYTE_W-2:0];
      cnt_d   = CNT_W'(1);
      valid_d = 1'b1;
      state_d = StShift;
`ifdef BYTE_SER_PARITY_EN
      par_d   = even_parity(fifo_rdata);
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
`ifdef BYTE_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
`ifdef BYTE_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ByteReady = !fifo_full;
  assign DataOut   = dout_q;
  assign BitValid  = valid_q;
  assign Busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboarded bench for byte_serializer: accepted bytes become an expected bit queue,
// and the monitor pops one bit per enabled edge.
module tb_byte_serializer;

  localparam int unsigned DEPTH = 4;
  localparam logic        IDLE  = 1'b0;
`ifdef BYTE_SER_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif

  logic                   Clock = 1'b0;
  logic                   Reset = 1'b0;
  logic [7:0]             DataByte = 8'h00;
  logic                   ByteValid = 1'b0;
  logic                   ByteReady;
  logic                   BitEn = 1'b0;
  logic                   DataOut;
  logic                   BitValid;
  logic                   Busy;
  logic [$clog2(DEPTH):0] Level;

  always #5 Clock = ~Clock;

  byte_serializer #(
    .DEPTH      (DEPTH),
    .IDLE_LEVEL (IDLE)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DataByte  (DataByte),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .BitEn     (BitEn),
    .DataOut   (DataOut),
    .BitValid  (BitValid),
    .Busy      (Busy),
    .Level     (Level)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   exp_q[$];
  int   pushed_now = 0;
  logic exp_dout  = IDLE;
  logic exp_valid = 1'b0;
  logic en_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus side of the scoreboard: every accepted byte queues its serial image.
  always @(posedge Clock) begin
    pushed_now = 0;
    if (Reset && ByteValid && ByteReady) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(DataByte[i]);
`ifdef BYTE_SER_PARITY_EN
      exp_q.push_back(^DataByte);
`endif
      pushed_now = BPB;
    end
  end

  // Bits pushed on this very edge are not yet available to the line.
  always @(posedge Clock) begin
    en_s = BitEn;
    #1;
    if (Reset) begin
      if (en_s) begin
        if (exp_q.size() > pushed_now) begin
          exp_dout  = exp_q.pop_front();
          exp_valid = 1'b1;
        end else begin
          exp_dout  = IDLE;
          exp_valid = 1'b0;
        end
      end
      check("data_out", DataOut, exp_dout);
      check("bit_valid", BitValid, exp_valid);
      check("busy", Busy, exp_valid || (exp_q.size() != 0));
    end
  end

  always @(negedge Reset) begin
    exp_q.delete();
    exp_dout  = IDLE;
    exp_valid = 1'b0;
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  int         cnt, rises;
  logic       prev;
  logic [7:0] bytes [5];

  initial begin
    repeat (3) tick();
    check("rst_data_out", DataOut, IDLE);
    check("rst_bit_valid", BitValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_level", Level, 0);
    check("rst_byte_ready", ByteReady, 1);
    #1 Reset = 1'b1;
    tick();

    // Single byte latency and bit values
    BitEn = 1'b1; DataByte = 8'hFD; ByteValid = 1'b1;
    tick();
    ByteValid = 1'b0;
    check("no_fallthrough", BitValid, 0);
    tick();
    check("msb_valid", BitValid, 1);
    check("msb_value", DataOut, 1);
    repeat (6) tick();
    check("bit1_value", DataOut, 0);
    tick();
    check("lsb_valid", BitValid, 1);
    check("lsb_value", DataOut, 1);
    tick();
`ifdef BYTE_SER_PARITY_EN
    check("parity_valid", BitValid, 1);
    check("parity_value", DataOut, 1);
    tick();
`endif
    check("end_valid", BitValid, 0);
    check("end_idle_level", DataOut, IDLE);
    repeat (3) tick();

    // Back-to-back bytes form one contiguous run
    DataByte = 8'hFD; ByteValid = 1'b1;
    tick();
    DataByte = 8'h00;
    tick();
    ByteValid = 1'b0;
    cnt = 0; rises = 0; prev = 1'b0;
    for (int k = 0; k < 2 * BPB + 5; k++) begin
      if (BitValid) cnt++;
      if (BitValid && !prev) rises++;
      prev = BitValid;
      tick();
    end
    check("b2b_valid_cycles", cnt, 2 * BPB);
    check("b2b_single_run", rises, 1);

    // Backpressure with BitEn low
    BitEn = 1'b0;
    for (int k = 0; k < 5; k++) bytes[k] = 8'($urandom);
    ByteValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      DataByte = bytes[k];
      tick();
    end
    DataByte = bytes[4];
    check("full_level", Level, 4);
    check("full_ready", ByteReady, 0);
    tick();
    check("held_level", Level, 4);
    check("held_no_bits", BitValid, 0);
    BitEn = 1'b1;
    tick();
    check("pop_level", Level, 3);
    check("pop_ready", ByteReady, 1);
    tick();
    ByteValid = 1'b0;
    check("fifth_level", Level, 4);
    repeat (5 * BPB + 5) tick();
    check("drain_level", Level, 0);
    check("drain_busy", Busy, 0);

    // BitEn every third cycle stretches each bit to three cycles
    DataByte = 8'hA5; ByteValid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3 * BPB + 9; k++) begin
      BitEn = (k % 3 == 0);
      tick();
      if (k == 0) ByteValid = 1'b0;
      if (BitValid) cnt++;
    end
    check("slow_valid_cycles", cnt, 3 * BPB);

    // Asynchronous reset mid-byte
    BitEn = 1'b1; DataByte = 8'hFF; ByteValid = 1'b1;
    repeat (3) tick();
    ByteValid = 1'b0;
    tick();
    check("pre_rst_level", Level, 2);
    check("pre_rst_valid", BitValid, 1);
    #1 Reset = 1'b0;
    #1;
    check("arst_data_out", DataOut, IDLE);
    check("arst_bit_valid", BitValid, 0);
    check("arst_level", Level, 0);
    check("arst_ready", ByteReady, 1);
    check("arst_busy", Busy, 0);
    tick();
    #1 Reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (BitValid) cnt++;
    end
    check("post_rst_no_bits", cnt, 0);

    // Randomised traffic
    for (int k = 0; k < 500; k++) begin
      BitEn     = ($urandom_range(0, 3) != 0);
      ByteValid = $urandom_range(0, 1) == 1;
      DataByte  = 8'($urandom);
      tick();
    end
    ByteValid = 1'b0; BitEn = 1'b1;
    repeat ((DEPTH + 2) * BPB + 4) tick();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_busy", Busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
